// File: rtl/seq2b8lv_autoplayer.sv
// seq2b8lv_autoplayer: records the symbols shown by the 2-bit sequence game
// and plays them back as timed one-hot button presses.
//
// state | meaning
// IDLE  | disabled, buttons released
// WATCH | recording displayed symbols, waiting for the game to go quiet
// PRESS | holding the button for mem[idx]
// REL   | all buttons released between presses
// DONE  | game reported a win, hold until en drops
module seq2b8lv_autoplayer #(
  parameter int DEPTH = 8,
  parameter int GAP   = 16,
  parameter int PRESS = 4,
  parameter int REL   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       disp_en,
  input  logic [3:0] l,
  input  logic       win,
  output logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WATCH = 3'd1;
  localparam logic [2:0] S_PRESS = 3'd2;
  localparam logic [2:0] S_REL   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C   = 4'(DEPTH);
  localparam logic [7:0] GAP_END   = 8'(GAP - 1);
  localparam logic [7:0] PRESS_END = 8'(PRESS - 1);
  localparam logic [7:0] REL_END   = 8'(REL - 1);

  logic [2:0] state;
  logic       disp_en_d;
  logic       cap_pending;
  logic [7:0] quiet;
  logic [7:0] t;
  logic [3:0] idx;
  logic [3:0] idx_nxt;
  logic [1:0] mem [0:DEPTH-1];

  logic       rise;
  logic       capture;
  logic       store;
  logic       l_legal;
  logic [1:0] sym;

  function automatic logic [3:0] onehot(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

  // Decode the one-hot light pattern; anything else is illegal.
  always_comb begin
    sym     = 2'd0;
    l_legal = 1'b1;
    case (l)
      4'b0001: sym = 2'd0;
      4'b0010: sym = 2'd1;
      4'b0100: sym = 2'd2;
      4'b1000: sym = 2'd3;
      default: l_legal = 1'b0;
    endcase
  end

  assign rise    = disp_en & ~disp_en_d;
  assign capture = cap_pending & (state == S_WATCH);
  // Only write memory when the state logic actually takes the capture.
  assign store   = capture & en & ~win & l_legal & (count != DEPTH_C);
  assign idx_nxt = idx + 4'd1;
  assign busy    = (state == S_WATCH) | (state == S_PRESS) | (state == S_REL);
  assign done    = (state == S_DONE);

  // Symbol memory; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (store) mem[count[AW-1:0]] <= sym;
  end

  // Main sequencer: en=0 beats win, win beats normal state progression.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      b           <= 4'd0;
      count       <= 4'd0;
      err         <= 1'b0;
      disp_en_d   <= 1'b0;
      cap_pending <= 1'b0;
      quiet       <= 8'd0;
      t           <= 8'd0;
      idx         <= 4'd0;
    end else begin
      disp_en_d   <= disp_en;
      // Strobes seen outside WATCH never turn into captures.
      cap_pending <= rise & (state == S_WATCH);
      if (!en) begin
        state <= S_IDLE;
        b     <= 4'd0;
      end else if (win && (state != S_IDLE)) begin
        state <= S_DONE;
        b     <= 4'd0;
      end else begin
        case (state)
          S_IDLE: begin
            b     <= 4'd0;
            state <= S_WATCH;
            count <= 4'd0;
            quiet <= 8'd0;
          end
          S_WATCH: begin
            if (capture) begin
              if (!l_legal) begin
                err <= 1'b1;
              end else begin
                quiet <= 8'd0;
                if (count == DEPTH_C) err <= 1'b1;
                else count <= count + 4'd1;
              end
            end else if (count != 4'd0) begin
              if (quiet == GAP_END) begin
                state <= S_PRESS;
                idx   <= 4'd0;
                t     <= 8'd0;
                b     <= onehot(mem[0]);
              end else begin
                quiet <= quiet + 8'd1;
              end
            end else begin
              quiet <= 8'd0;
            end
          end
          S_PRESS: begin
            if (t == PRESS_END) begin
              state <= S_REL;
              t     <= 8'd0;
              b     <= 4'd0;
            end else begin
              t <= t + 8'd1;
            end
          end
          S_REL: begin
            if (t == REL_END) begin
              t <= 8'd0;
              if (idx == count - 4'd1) begin
                // Next round re-shows the whole sequence, so record afresh.
                state <= S_WATCH;
                count <= 4'd0;
                quiet <= 8'd0;
              end else begin
                state <= S_PRESS;
                idx   <= idx_nxt;
                b     <= onehot(mem[idx_nxt[AW-1:0]]);
              end
            end else begin
              t <= t + 8'd1;
            end
          end
          S_DONE: begin
            b <= 4'd0;
          end
          default: begin
            state <= S_IDLE;
            b     <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq2b8lv_autoplayer.sv
// Bench for seq2b8lv_autoplayer: expected presses are queued as the game
// strobes are driven and popped when the player raises a button.
module tb_seq2b8lv_autoplayer;

  logic       clk;
  logic       reset;
  logic       en;
  logic       disp_en;
  logic [3:0] l;
  logic       win;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] count;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] exp_q[$];
  logic       mon_en    = 1'b1;
  int         exp_width = 4;
  logic [3:0] b_prev    = 4'd0;
  int         hi_cnt    = 0;

  seq2b8lv_autoplayer dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .disp_en (disp_en),
    .l       (l),
    .win     (win),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare each new press against the queue and check its width.
  always @(negedge clk) begin
    if (mon_en) begin
      if (b != 4'd0 && b_prev == 4'd0) begin
        if (exp_q.size() == 0) check("press_extra", b, 4'd0);
        else check("press_val", b, exp_q.pop_front());
        hi_cnt = 1;
      end else if (b != 4'd0) begin
        hi_cnt++;
      end else if (b_prev != 4'd0) begin
        check("press_width", hi_cnt, exp_width);
      end
    end
    b_prev = b;
  end

  task automatic strobe(input logic [3:0] lv, input int spacing);
    disp_en = 1'b1;
    l       = lv;
    @(negedge clk);
    disp_en = 1'b0;
    repeat (spacing - 1) @(negedge clk);
  endtask

  task automatic wait_press();
    int n;
    n = 0;
    while (b == 4'd0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("press_seen", (b != 4'd0), 1'b1);
  endtask

  task automatic wait_round(input int max_cyc);
    int n;
    n = 0;
    while (count != 4'd0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("round_end_count", count, 4'd0);
    check("round_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int busy_low;
    logic [3:0] lv;

    reset   = 1'b1;
    en      = 1'b0;
    disp_en = 1'b0;
    l       = 4'd0;
    win     = 1'b0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_b", b, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_count", count, 4'd0);
    reset = 1'b1;
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("watch_busy", busy, 1'b1);

    // Single symbol: press appears GAP cycles after the capture.
    disp_en = 1'b1;
    l       = 4'b0010;
    exp_q.push_back(4'b0010);
    n = 0;
    while (b == 4'd0 && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) disp_en = 1'b0;
    end
    check("gap_latency", n, 18);
    check("a_count", count, 4'd1);
    wait_round(200);
    check("a_busy_watch", busy, 1'b1);

    // Three symbols: replay occupies 3*(PRESS+REL) cycles with busy high.
    foreach (lv_tab_b[i]) begin
      exp_q.push_back(lv_tab_b[i]);
      strobe(lv_tab_b[i], 5);
    end
    check("b_count", count, 4'd3);
    wait_press();
    n = 0;
    busy_low = 0;
    while (count != 4'd0 && n < 200) begin
      @(negedge clk);
      n++;
      if (!busy) busy_low++;
    end
    check("replay_len", n, 24);
    check("replay_busy_low", busy_low, 0);
    check("b_queue_empty", exp_q.size(), 0);

    // Overflow: 9 strobes, only 8 stored and replayed.
    for (int i = 0; i < 9; i++) begin
      lv = 4'b0001 << (i % 4);
      if (i < 8) exp_q.push_back(lv);
      strobe(lv, 3);
      if (i == 7) begin
        check("ovf_count8", count, 4'd8);
        check("ovf_err_before", err, 1'b0);
      end
    end
    check("ovf_count_hold", count, 4'd8);
    check("ovf_err", err, 1'b1);
    wait_round(400);

    // Asynchronous reset in the middle of a press.
    mon_en = 1'b0;
    strobe(4'b0100, 3);
    wait_press();
    check("pre_rst_b", b, 4'b0100);
    #2 reset = 1'b0;
    #1;
    check("async_rst_b", b, 4'd0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_count", count, 4'd0);
    @(negedge clk);
    reset = 1'b1;
    check("rst_err_clear", err, 1'b0);
    mon_en = 1'b1;
    @(negedge clk);

    // Illegal light pattern, then a normal one.
    strobe(4'b0110, 4);
    check("illegal_err", err, 1'b1);
    check("illegal_count", count, 4'd0);
    exp_q.push_back(4'b0100);
    strobe(4'b0100, 4);
    check("legal_after_count", count, 4'd1);
    wait_round(200);

    // Win pre-empts a press in its second cycle.
    exp_width = 2;
    exp_q.push_back(4'b0001);
    strobe(4'b0001, 3);
    wait_press();
    @(negedge clk);
    win = 1'b1;
    @(negedge clk);
    check("win_b", b, 4'd0);
    check("win_done", done, 1'b1);
    check("win_busy", busy, 1'b0);
    win = 1'b0;
    strobe(4'b1000, 3);
    strobe(4'b0010, 3);
    check("done_count_hold", count, 4'd1);
    check("done_b", b, 4'd0);
    check("done_hold", done, 1'b1);
    en = 1'b0;
    @(negedge clk);
    check("idle_done", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_count", count, 4'd1);
    check("idle_err", err, 1'b1);
    check("end_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  logic [3:0] lv_tab_b [0:2] = '{4'b1000, 4'b0001, 4'b1000};

endmodule
